// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BHT of saturating counters merged with a tagged BTB.
// Optional gshare indexing when BP_GSHARE_EN is defined.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            ready_o,
  output logic            mispredict_o,
  output logic [31:0]     stat_branches_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               ready_q;
  logic               mis_q;
  logic [31:0]        br_q;
  logic [31:0]        mp_q;

  logic               valid_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_q   [ENTRIES];
  logic [XLEN-1:0]    tgt_q   [ENTRIES];

  logic [IDX_W-1:0]   hist;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0]   ghr_q;
  assign hist = IDX_W'(ghr_q);
`else
  assign hist = '0;
`endif

  logic [IDX_W-1:0]   p_idx;
  logic [TAG_W-1:0]   p_tag;
  logic               p_hit;
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               u_hit;
  logic               acc;
  logic               mis;
  logic [CNT_W-1:0]   cnt_d;

  assign p_idx = if_pc_i[IDX_W+1:2] ^ hist;
  assign p_tag = if_pc_i[XLEN-1:IDX_W+2];
  assign p_hit = ready_q & valid_q[p_idx] & (tag_q[p_idx] == p_tag);

  assign pred_taken_o  = p_hit & cnt_q[p_idx][CNT_W-1];
  assign pred_target_o = pred_taken_o ? tgt_q[p_idx] : if_pc_i + XLEN'(4);

  assign u_idx = upd_pc_i[IDX_W+1:2] ^ hist;
  assign u_tag = upd_pc_i[XLEN-1:IDX_W+2];
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign acc   = (state_q == S_RUN) & upd_valid_i;

  assign mis = (upd_pred_taken_i != upd_taken_i) |
               (upd_pred_taken_i & upd_taken_i &
                (upd_pred_target_i != upd_target_i));

  assign ready_o         = ready_q;
  assign mispredict_o    = mis_q;
  assign stat_branches_o = br_q;
  assign stat_mispred_o  = mp_q;

  logic unused_ok;
  assign unused_ok = ^{if_pc_i[1:0], upd_pc_i[1:0], 1'(GHR_W)};

  // Next counter value: allocate weak state on miss, saturate on hit.
  always_comb begin
    cnt_d = cnt_q[u_idx];
    if (!u_hit) begin
      cnt_d = upd_taken_i ? CNT_WT : CNT_WNT;
    end else if (upd_taken_i) begin
      if (cnt_q[u_idx] != CNT_MAX) cnt_d = cnt_q[u_idx] + 1'b1;
    end else begin
      if (cnt_q[u_idx] != '0) cnt_d = cnt_q[u_idx] - 1'b1;
    end
  end

  // Control FSM, statistics, mispredict pulse and global history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      br_q    <= '0;
      mp_q    <= '0;
`ifdef BP_GSHARE_EN
      ghr_q   <= '0;
`endif
    end else begin
      mis_q <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (upd_valid_i) begin
            if (br_q != '1) br_q <= br_q + 1'b1;
            if (mis) begin
              mis_q <= 1'b1;
              if (mp_q != '1) mp_q <= mp_q + 1'b1;
            end
`ifdef BP_GSHARE_EN
            ghr_q <= {ghr_q[GHR_W-2:0], upd_taken_i};
`endif
          end
        end
      endcase
    end
  end

  // Table storage: cleared one entry per INIT cycle, written on accepted updates.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == S_INIT) begin
        valid_q[ptr_q] <= 1'b0;
        cnt_q[ptr_q]   <= CNT_WNT;
      end else if (acc) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        cnt_q[u_idx]   <= cnt_d;
        if (!u_hit || upd_taken_i) tgt_q[u_idx] <= upd_target_i;
      end
    end
  end

endmodule
